// File: rtl/isi_hist_pkg.sv
// Shared types and helpers for the ISI histogram accumulator.
// State encoding and the saturation limits of the ISI counter and the histogram bins.
package isi_hist_pkg;

   typedef enum logic [2:0] {
      S_CLR,
      S_HOLD,
      S_IDLE,
      S_RD,
      S_WR
   } hist_state_e;

   // All-ones value of a counter of the given width (ISI_MAX / CNT_MAX)
   function automatic logic [31:0] isi_max(input int unsigned bits);
      return (32'd1 << bits) - 32'd1;
   endfunction

   function automatic logic [31:0] cnt_max(input int unsigned bits);
      return (32'd1 << bits) - 32'd1;
   endfunction

endpackage

// File: rtl/isi_hist_ram.sv
// Simple dual-port histogram RAM: port A read/write for the RMW path, port B registered read.
// Port B returns the old contents when it reads the bin port A writes in the same cycle.
module isi_hist_ram #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic [DW-1:0] a_rdata,
   input  logic [AW-1:0] b_addr,
   output logic [DW-1:0] b_rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (a_we) begin
         mem[a_addr] <= a_wdata;
      end
   end

   // Output registers carry the reset so the read port starts at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         a_rdata <= mem[a_addr];
         b_rdata <= mem[b_addr];
      end
   end

endmodule

// File: rtl/isi_hist_accum.sv
// Inter-spike interval histogram: measures ISI in tick_en units and bins it via a 2-cycle RMW.
// Optional HIST_TOTAL_EN adds total_cnt, the number of completed RMW writes since the last clear.
module isi_hist_accum
   import isi_hist_pkg::*;
#(
   parameter int BIT_ISI = 8,
   parameter int BIT_CNT = 16
) (
   input  logic               clk_main,
   input  logic               rst,
   input  logic               tick_en,
   input  logic               tstamp_z,
   input  logic               clr_hist,
   input  logic [BIT_ISI-1:0] rd_addr,
   output logic [BIT_CNT-1:0] rd_data,
   output logic               busy,
   output logic [BIT_ISI-1:0] isi_cur,
   output logic               err_drop
`ifdef HIST_TOTAL_EN
   ,
   output logic [BIT_CNT+BIT_ISI-1:0] total_cnt
`endif
);

   localparam logic [BIT_ISI-1:0] ISI_MAX = BIT_ISI'(isi_max(BIT_ISI));
   localparam logic [BIT_CNT-1:0] CNT_MAX = BIT_CNT'(cnt_max(BIT_CNT));

   hist_state_e        state;
   logic [BIT_ISI-1:0] sweep_addr;
   logic [BIT_ISI-1:0] bin;
   logic               armed;
   logic               ram_we;
   logic [BIT_ISI-1:0] ram_addr;
   logic [BIT_CNT-1:0] ram_wdata;
   logic [BIT_CNT-1:0] ram_rdata;

   // A clear arriving during S_WR must cancel that cycle's write
   assign ram_we    = (state == S_CLR) || ((state == S_WR) && !clr_hist);
   assign ram_addr  = (state == S_CLR) ? sweep_addr : bin;
   assign ram_wdata = (state == S_CLR)        ? '0 :
                      (ram_rdata == CNT_MAX)  ? ram_rdata :
                                                ram_rdata + BIT_CNT'(1);
   assign busy      = (state != S_IDLE);

   isi_hist_ram #(
      .AW (BIT_ISI),
      .DW (BIT_CNT)
   ) u_ram (
      .clk     (clk_main),
      .rst     (rst),
      .a_we    (ram_we),
      .a_addr  (ram_addr),
      .a_wdata (ram_wdata),
      .a_rdata (ram_rdata),
      .b_addr  (rd_addr),
      .b_rdata (rd_data)
   );

   always_ff @(posedge clk_main or posedge rst) begin
      if (rst) begin
         state      <= S_CLR;
         sweep_addr <= '0;
         bin        <= '0;
         isi_cur    <= '0;
         armed      <= 1'b0;
         err_drop   <= 1'b0;
      end else begin
         case (state)
            S_CLR: begin
               isi_cur    <= '0;
               armed      <= 1'b0;
               sweep_addr <= sweep_addr + BIT_ISI'(1);
               if (sweep_addr == ISI_MAX) begin
                  state <= clr_hist ? S_HOLD : S_IDLE;
               end
            end
            S_HOLD: begin
               isi_cur <= '0;
               armed   <= 1'b0;
               if (!clr_hist) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               if (clr_hist) begin
                  state      <= S_CLR;
                  sweep_addr <= '0;
                  isi_cur    <= '0;
                  armed      <= 1'b0;
                  err_drop   <= 1'b0;
               end else begin
                  if (state == S_RD) begin
                     state <= S_WR;
                  end else if (state == S_WR) begin
                     state <= S_IDLE;
                  end
                  // The interval counter runs independently of the RMW sequence
                  if (tick_en) begin
                     if (tstamp_z) begin
                        isi_cur <= '0;
                        armed   <= 1'b1;
                        if (armed) begin
                           if (state == S_IDLE) begin
                              bin   <= isi_cur;
                              state <= S_RD;
                           end else begin
                              err_drop <= 1'b1;
                           end
                        end
                     end else if (isi_cur != ISI_MAX) begin
                        isi_cur <= isi_cur + BIT_ISI'(1);
                     end
                  end
               end
            end
         endcase
      end
   end

`ifdef HIST_TOTAL_EN
   always_ff @(posedge clk_main or posedge rst) begin
      if (rst) begin
         total_cnt <= '0;
      end else if (clr_hist || (state == S_CLR) || (state == S_HOLD)) begin
         total_cnt <= '0;
      end else if ((state == S_WR) && (total_cnt != '1)) begin
         total_cnt <= total_cnt + (BIT_CNT+BIT_ISI)'(1);
      end
   end
`endif

endmodule
